// File: rtl/iter_arbiter_if.sv
// Request/mapper channel bundle for iter_arbiter: engine-side beats in, one mapped beat out.
// master = engines + colour mapper side, slave = the arbiter.
interface iter_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ITER_W  = 8,
    parameter int TAG_W   = 16,
    parameter int SRC_W   = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ITER_W-1:0] req_iter;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      map_valid;
    logic [ITER_W-1:0]         map_iter;
    logic [TAG_W-1:0]          map_tag;
    logic [SRC_W-1:0]          map_src;
    logic                      map_last;
    logic                      map_ready;
    logic                      busy;

    modport master (
        output req_valid, req_iter, req_tag, req_last, map_ready,
        input  req_ready, map_valid, map_iter, map_tag, map_src, map_last, busy
    );

    modport slave (
        input  req_valid, req_iter, req_tag, req_last, map_ready,
        output req_ready, map_valid, map_iter, map_tag, map_src, map_last, busy
    );
endinterface

// File: rtl/iter_arbiter.sv
// Round-robin, burst-locking arbiter feeding one colour mapper from NUM_REQ iteration engines.
// Define ITER_ARB_STATS_EN to add per-engine accepted-beat counters (stat_sel/stat_clr/stat_count).
module iter_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ITER_W  = 8,
    parameter int TAG_W   = 16,
    parameter int SRC_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    iter_arbiter_if.slave     bus
`ifdef ITER_ARB_STATS_EN
    ,
    input  logic [SRC_W-1:0]  stat_sel,
    input  logic              stat_clr,
    output logic [31:0]       stat_count
`endif
);
    typedef enum logic {IDLE, LOCK} state_t;

    state_t            r_state;
    logic [SRC_W-1:0]  r_owner;
    logic [SRC_W-1:0]  r_rr_ptr;
    logic              r_map_valid;
    logic [ITER_W-1:0] r_map_iter;
    logic [TAG_W-1:0]  r_map_tag;
    logic [SRC_W-1:0]  r_map_src;
    logic              r_map_last;

    logic [SRC_W-1:0]  w_grant;
    logic [SRC_W-1:0]  w_cand;
    logic              w_has_grant;
    logic              w_gvalid;
    logic [ITER_W-1:0] w_iter;
    logic [TAG_W-1:0]  w_tag;
    logic              w_last;
    logic              w_load;
    logic              w_accept;

    // Descending scan so the candidate closest to rr_ptr is the last one written.
    always_comb begin
        w_grant     = '0;
        w_cand      = '0;
        w_has_grant = 1'b0;
        if (r_state == LOCK) begin
            w_grant     = r_owner;
            w_has_grant = 1'b1;
        end else begin
            for (int unsigned k = NUM_REQ; k > 0; k--) begin
                w_cand = SRC_W'((32'(r_rr_ptr) + k - 1) % NUM_REQ);
                if (bus.req_valid[w_cand]) begin
                    w_grant     = w_cand;
                    w_has_grant = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_gvalid = 1'b0;
        w_iter   = '0;
        w_tag    = '0;
        w_last   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (32'(w_grant) == i) begin
                w_gvalid = bus.req_valid[i];
                w_iter   = bus.req_iter[i*ITER_W +: ITER_W];
                w_tag    = bus.req_tag[i*TAG_W +: TAG_W];
                w_last   = bus.req_last[i];
            end
        end
    end

    assign w_load   = !r_map_valid || bus.map_ready;
    assign w_accept = reset && w_load && w_has_grant && w_gvalid;

    always_comb begin
        bus.req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = reset && w_load && w_has_grant && (32'(w_grant) == i);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_map_valid <= 1'b0;
            r_map_iter  <= '0;
            r_map_tag   <= '0;
            r_map_src   <= '0;
            r_map_last  <= 1'b0;
        end else begin
            if (w_load) begin
                r_map_valid <= w_accept;
                if (w_accept) begin
                    r_map_iter <= w_iter;
                    r_map_tag  <= w_tag;
                    r_map_src  <= w_grant;
                    r_map_last <= w_last;
                end
            end
            if (w_accept) begin
                if (w_last) begin
                    r_state  <= IDLE;
                    r_rr_ptr <= SRC_W'((32'(w_grant) + 1) % NUM_REQ);
                end else begin
                    r_state <= LOCK;
                    r_owner <= w_grant;
                end
            end
        end
    end

    assign bus.map_valid = r_map_valid;
    assign bus.map_iter  = r_map_iter;
    assign bus.map_tag   = r_map_tag;
    assign bus.map_src   = r_map_src;
    assign bus.map_last  = r_map_last;
    assign bus.busy      = (r_state == LOCK) || r_map_valid;

`ifdef ITER_ARB_STATS_EN
    logic [31:0] r_cnt [NUM_REQ];
    logic [31:0] r_stat_count;
    logic [31:0] w_stat;

    always_comb begin
        w_stat = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (32'(stat_sel) == i) w_stat = r_cnt[i];
        end
    end

    // Clear wins over a same-cycle increment and also zeroes the read-back register.
    always_ff @(posedge clk) begin
        if (!reset || stat_clr) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
            r_stat_count <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (w_accept && (32'(w_grant) == i)) r_cnt[i] <= r_cnt[i] + 32'd1;
            end
            r_stat_count <= w_stat;
        end
    end

    assign stat_count = r_stat_count;
`endif
endmodule

// File: tb/tb_iter_arbiter.sv
// Self-checking bench for iter_arbiter: directed scenarios plus randomized traffic against
// a transaction-level reference model of the round-robin / burst-lock rules.
module tb_iter_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ITER_W  = 8;
    localparam int TAG_W   = 16;
    localparam int SRC_W   = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    iter_arbiter_if #(.NUM_REQ(NUM_REQ), .ITER_W(ITER_W), .TAG_W(TAG_W), .SRC_W(SRC_W)) bus ();

`ifdef ITER_ARB_STATS_EN
    logic [SRC_W-1:0] stat_sel = '0;
    logic             stat_clr = 1'b0;
    logic [31:0]      stat_count;
`endif

    iter_arbiter #(.NUM_REQ(NUM_REQ), .ITER_W(ITER_W), .TAG_W(TAG_W), .SRC_W(SRC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ITER_ARB_STATS_EN
        ,
        .stat_sel   (stat_sel),
        .stat_clr   (stat_clr),
        .stat_count (stat_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: arbitration state plus the expected output beat.
    bit                m_locked;
    int                m_owner;
    int                m_ptr;
    bit                m_mv;
    logic [ITER_W-1:0] m_iter;
    logic [TAG_W-1:0]  m_tag;
    int                m_src;
    bit                m_last;
    logic [NUM_REQ-1:0] exp_ready;
    logic [NUM_REQ-1:0] got_ready;

    task automatic drive(input int e, input bit v, input logic [ITER_W-1:0] it,
                         input logic [TAG_W-1:0] tg, input bit l);
        bus.req_valid[e] = v;
        bus.req_iter[e*ITER_W +: ITER_W] = it;
        bus.req_tag[e*TAG_W +: TAG_W] = tg;
        bus.req_last[e] = l;
    endtask

    // Samples req_ready before the edge, advances the model, then steps past the edge.
    task automatic tick();
        int g;
        bit hasg;
        bit load;
        bit acc;
        #1;
        got_ready = bus.req_ready;
        load = !m_mv || bus.map_ready;
        hasg = 1'b0;
        g = 0;
        if (m_locked) begin
            hasg = 1'b1;
            g = m_owner;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!hasg && bus.req_valid[(m_ptr + k) % NUM_REQ]) begin
                    hasg = 1'b1;
                    g = (m_ptr + k) % NUM_REQ;
                end
            end
        end
        exp_ready = '0;
        if (reset && load && hasg) exp_ready[g] = 1'b1;
        acc = reset && load && hasg && bus.req_valid[g];
        if (!reset) begin
            m_locked = 1'b0; m_owner = 0; m_ptr = 0;
            m_mv = 1'b0; m_iter = '0; m_tag = '0; m_src = 0; m_last = 1'b0;
        end else begin
            if (load) begin
                m_mv = acc;
                if (acc) begin
                    m_iter = bus.req_iter[g*ITER_W +: ITER_W];
                    m_tag  = bus.req_tag[g*TAG_W +: TAG_W];
                    m_src  = g;
                    m_last = bus.req_last[g];
                end
            end
            if (acc) begin
                if (bus.req_last[g]) begin
                    m_locked = 1'b0;
                    m_ptr = (g + 1) % NUM_REQ;
                end else begin
                    m_locked = 1'b1;
                    m_owner = g;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.req_valid = '0;
        bus.req_last = '0;
        bus.map_ready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.map_ready = 1'b1;
        for (int e = 0; e < NUM_REQ; e++) drive(e, 1'b1, ITER_W'(e), TAG_W'(e), 1'b1);
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (bus.map_valid !== 1'b0) begin
                errors++; $display("FAIL reset_map_valid got %b exp 0", bus.map_valid);
            end
            checks++;
            if (got_ready !== '0) begin
                errors++; $display("FAIL reset_req_ready got %b exp 0000", got_ready);
            end
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++; $display("FAIL reset_busy got %b exp 0", bus.busy);
            end
        end
    endtask

    task automatic test_rotation();
        logic [NUM_REQ-1:0] want;
        do_reset();
        for (int e = 0; e < NUM_REQ; e++) drive(e, 1'b1, ITER_W'(8'h40 + e), TAG_W'(e), 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick();
            want = '0;
            want[c % NUM_REQ] = 1'b1;
            checks++;
            if (got_ready !== want) begin
                errors++; $display("FAIL rot_ready c=%0d got %b exp %b", c, got_ready, want);
            end
            checks++;
            if (bus.map_valid !== 1'b1 || bus.map_src !== SRC_W'(c % NUM_REQ) ||
                bus.map_iter !== ITER_W'(8'h40 + c % NUM_REQ)) begin
                errors++;
                $display("FAIL rot_beat c=%0d got v=%b src=%0d iter=%h exp v=1 src=%0d iter=%h",
                         c, bus.map_valid, bus.map_src, bus.map_iter, c % NUM_REQ, 8'h40 + c % NUM_REQ);
            end
        end
    endtask

    task automatic test_lock();
        int exp_src [7] = '{1, 1, 1, 1, 1, 2, 0};
        do_reset();
        drive(0, 1'b1, 8'h00, 16'h0000, 1'b1);
        tick();
        for (int c = 0; c < 7; c++) begin
            drive(0, 1'b1, 8'h00, 16'h0000, 1'b1);
            drive(1, c < 5, ITER_W'(8'h10 + c), TAG_W'(16'h1000 + c), c == 4);
            drive(2, 1'b1, 8'h20, 16'h2000, 1'b1);
            drive(3, 1'b0, 8'h00, 16'h0000, 1'b0);
            tick();
            checks++;
            if (bus.map_valid !== 1'b1 || bus.map_src !== SRC_W'(exp_src[c])) begin
                errors++;
                $display("FAIL lock_src c=%0d got v=%b src=%0d exp v=1 src=%0d",
                         c, bus.map_valid, bus.map_src, exp_src[c]);
            end
            if (c < 5) begin
                checks++;
                if (bus.map_iter !== ITER_W'(8'h10 + c) || bus.map_last !== (c == 4)) begin
                    errors++;
                    $display("FAIL lock_payload c=%0d got iter=%h last=%b exp iter=%h last=%b",
                             c, bus.map_iter, bus.map_last, 8'h10 + c, c == 4);
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(0, 1'b1, 8'hA5, 16'h1234, 1'b1);
        tick();
        drive(0, 1'b1, 8'h5A, 16'h4321, 1'b1);
        bus.map_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus.map_valid !== 1'b1 || bus.map_iter !== 8'hA5 || bus.map_tag !== 16'h1234 ||
                bus.map_src !== 2'd0 || bus.map_last !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold c=%0d got v=%b iter=%h tag=%h exp v=1 iter=a5 tag=1234",
                         c, bus.map_valid, bus.map_iter, bus.map_tag);
            end
            checks++;
            if (got_ready !== '0) begin
                errors++; $display("FAIL stall_ready c=%0d got %b exp 0000", c, got_ready);
            end
        end
        bus.map_ready = 1'b1;
        tick();
        checks++;
        if (got_ready !== 4'b0001 || bus.map_iter !== 8'h5A || bus.map_tag !== 16'h4321) begin
            errors++;
            $display("FAIL stall_release got ready=%b iter=%h tag=%h exp ready=0001 iter=5a tag=4321",
                     got_ready, bus.map_iter, bus.map_tag);
        end
        drive(0, 1'b0, 8'h00, 16'h0000, 1'b0);
        tick();
        checks++;
        if (bus.map_valid !== 1'b0) begin
            errors++; $display("FAIL stall_nodup got v=%b exp 0", bus.map_valid);
        end
    endtask

    task automatic test_owner_gap();
        do_reset();
        drive(2, 1'b1, 8'h21, 16'h2100, 1'b0);
        tick();
        checks++;
        if (bus.map_src !== 2'd2 || bus.map_valid !== 1'b1) begin
            errors++; $display("FAIL gap_first got src=%0d v=%b exp src=2 v=1", bus.map_src, bus.map_valid);
        end
        drive(2, 1'b0, 8'h00, 16'h0000, 1'b0);
        drive(3, 1'b1, 8'h31, 16'h3100, 1'b1);
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (got_ready[3] !== 1'b0 || bus.map_valid !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL gap_wait c=%0d got rdy3=%b v=%b busy=%b exp rdy3=0 v=0 busy=1",
                         c, got_ready[3], bus.map_valid, bus.busy);
            end
        end
        drive(2, 1'b1, 8'h22, 16'h2200, 1'b1);
        tick();
        checks++;
        if (bus.map_src !== 2'd2 || bus.map_iter !== 8'h22 || bus.map_last !== 1'b1) begin
            errors++;
            $display("FAIL gap_last got src=%0d iter=%h last=%b exp src=2 iter=22 last=1",
                     bus.map_src, bus.map_iter, bus.map_last);
        end
        drive(2, 1'b0, 8'h00, 16'h0000, 1'b0);
        tick();
        checks++;
        if (bus.map_src !== 2'd3 || bus.map_iter !== 8'h31 || bus.map_valid !== 1'b1) begin
            errors++;
            $display("FAIL gap_next got src=%0d iter=%h v=%b exp src=3 iter=31 v=1",
                     bus.map_src, bus.map_iter, bus.map_valid);
        end
    endtask

    task automatic test_random();
        logic [27:0] exp_map;
        logic [27:0] got_map;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int e = 0; e < NUM_REQ; e++) begin
                drive(e, $urandom_range(0, 3) != 0, ITER_W'($urandom), TAG_W'($urandom),
                      $urandom_range(0, 3) == 0);
            end
            bus.map_ready = $urandom_range(0, 3) != 0;
            reset = $urandom_range(0, 79) != 0;
            tick();
            checks++;
            if (got_ready !== exp_ready) begin
                errors++; $display("FAIL rand_ready c=%0d got %b exp %b", c, got_ready, exp_ready);
            end
            exp_map = {m_mv, m_iter, m_tag, SRC_W'(m_src), m_last};
            got_map = {bus.map_valid, bus.map_iter, bus.map_tag, bus.map_src, bus.map_last};
            checks++;
            if (got_map !== exp_map) begin
                errors++; $display("FAIL rand_map c=%0d got %h exp %h", c, got_map, exp_map);
            end
            checks++;
            if (bus.busy !== (m_locked || m_mv)) begin
                errors++; $display("FAIL rand_busy c=%0d got %b exp %b", c, bus.busy, m_locked || m_mv);
            end
        end
        reset = 1'b1;
    endtask

`ifdef ITER_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        drive(0, 1'b1, 8'h01, 16'h0001, 1'b1);
        for (int c = 0; c < 10; c++) tick();
        drive(0, 1'b0, 8'h00, 16'h0000, 1'b0);
        drive(3, 1'b1, 8'h03, 16'h0003, 1'b1);
        for (int c = 0; c < 3; c++) tick();
        drive(3, 1'b0, 8'h00, 16'h0000, 1'b0);
        stat_sel = 2'd3;
        tick();
        checks++;
        if (stat_count !== 32'd3) begin
            errors++; $display("FAIL stats_eng3 got %0d exp 3", stat_count);
        end
        stat_sel = 2'd0;
        tick();
        checks++;
        if (stat_count !== 32'd10) begin
            errors++; $display("FAIL stats_eng0 got %0d exp 10", stat_count);
        end
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        checks++;
        if (stat_count !== 32'd0) begin
            errors++; $display("FAIL stats_clr got %0d exp 0", stat_count);
        end
        stat_sel = 2'd3;
        tick();
        checks++;
        if (stat_count !== 32'd0) begin
            errors++; $display("FAIL stats_after_clr got %0d exp 0", stat_count);
        end
    endtask
`endif

    initial begin
        bus.req_valid = '0;
        bus.req_iter = '0;
        bus.req_tag = '0;
        bus.req_last = '0;
        bus.map_ready = 1'b1;
        m_locked = 1'b0; m_owner = 0; m_ptr = 0;
        m_mv = 1'b0; m_iter = '0; m_tag = '0; m_src = 0; m_last = 1'b0;
        test_reset();
        test_rotation();
        test_lock();
        test_stall();
        test_owner_gap();
        test_random();
`ifdef ITER_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
